// File: rtl/pipe_prefix_sub_if.sv
// Operand/result bundle for the pipelined prefix subtractor.
// The optional signed-overflow output ovf exists only when PIPE_SUB_OVF_EN is defined.
// Master drives operands and samples results; slave is the subtractor.
interface pipe_prefix_sub_if #(
  parameter int WIDTH = 32
);
  logic             vin;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             bin;
  logic             vout;
  logic [WIDTH-1:0] d;
  logic             bout;
`ifdef PIPE_SUB_OVF_EN
  logic             ovf;

  modport master (output vin, x, y, bin, input vout, d, bout, ovf);
  modport slave  (input vin, x, y, bin, output vout, d, bout, ovf);
`else
  modport master (output vin, x, y, bin, input vout, d, bout);
  modport slave  (input vin, x, y, bin, output vout, d, bout);
`endif
endinterface

// File: rtl/pipe_prefix_sub.sv
// Pipelined Kogge-Stone parallel-prefix subtractor: d = x - y - bin, bout = borrow.
// Computed as x + ~y + cin with cin = ~bin; borrow-out is the inverted carry-out.
// Pipeline: one operand-formation stage, LEVELS prefix stages, one sum stage,
// so a result appears LEVELS+2 enabled edges after its operands are sampled.
// ce=0 freezes every register; rst (synchronous, active-high) clears all of them
// and takes priority over ce.
// Optional feature macro: PIPE_SUB_OVF_EN adds the signed-overflow output ovf,
// fed by x/y MSBs carried alongside the data.
module pipe_prefix_sub #(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  pipe_prefix_sub_if.slave  bus
);

  localparam int LEVELS = $clog2(WIDTH);

  // Stage-1 combinational operand formation
  logic [WIDTH-1:0] ny_s;
  logic [WIDTH-1:0] g_in_s;
  logic [WIDTH-1:0] p_in_s;
  logic             cin_s;

  // Pipeline state. Index 0 is the operand stage, index k holds level-k prefix results.
  logic [WIDTH-1:0] g_r   [0:LEVELS];
  logic [WIDTH-1:0] gp_r  [0:LEVELS-1];
  logic [WIDTH-1:0] p_r   [0:LEVELS];
  logic             cin_r [0:LEVELS];
  logic             v_r   [0:LEVELS];

  // Next-state values of the prefix levels
  logic [WIDTH-1:0] g_nx_s  [1:LEVELS];
  logic [WIDTH-1:0] gp_nx_s [1:LEVELS-1];

  // Sum stage
  logic [WIDTH-1:0] d_s;
  logic [WIDTH-1:0] d_r;
  logic             bout_r;
  logic             vout_r;

  // Kogge-Stone black cell: group generate of (hi, lo) pair
  function automatic logic ks_gen(input logic g_hi, input logic p_hi, input logic g_lo);
    return g_hi | (p_hi & g_lo);
  endfunction

  // Kogge-Stone black cell: group propagate of (hi, lo) pair
  function automatic logic ks_prop(input logic p_hi, input logic p_lo);
    return p_hi & p_lo;
  endfunction

  // Bit generate/propagate from x and ~y, with the carry-in folded into bit 0 generate
  always_comb begin
    ny_s      = ~bus.y;
    cin_s     = ~bus.bin;
    p_in_s    = bus.x ^ ny_s;
    g_in_s    = bus.x & ny_s;
    g_in_s[0] = ks_gen(g_in_s[0], p_in_s[0], cin_s);
  end

  // Prefix levels 1..LEVELS-1 combine both G and P at span 2^(k-1)
  always_comb begin
    for (int k = 1; k < LEVELS; k++) begin
      g_nx_s[k]  = g_r[k-1];
      gp_nx_s[k] = gp_r[k-1];
      for (int i = 0; i < WIDTH; i++) begin
        if (i >= (32'd1 << (k - 1))) begin
          g_nx_s[k][i]  = ks_gen(g_r[k-1][i], gp_r[k-1][i], g_r[k-1][i - (32'd1 << (k - 1))]);
          gp_nx_s[k][i] = ks_prop(gp_r[k-1][i], gp_r[k-1][i - (32'd1 << (k - 1))]);
        end else begin
          g_nx_s[k][i]  = g_r[k-1][i];
          gp_nx_s[k][i] = gp_r[k-1][i];
        end
      end
    end
  end

  // Final prefix level needs only group generate (span WIDTH/2)
  always_comb begin
    g_nx_s[LEVELS] = g_r[LEVELS-1];
    for (int i = 0; i < WIDTH; i++) begin
      if (i >= (WIDTH / 2)) begin
        g_nx_s[LEVELS][i] = ks_gen(g_r[LEVELS-1][i], gp_r[LEVELS-1][i],
                                   g_r[LEVELS-1][i - (WIDTH / 2)]);
      end else begin
        g_nx_s[LEVELS][i] = g_r[LEVELS-1][i];
      end
    end
  end

  // Difference bits: each p xored with the carry into that bit (cin for bit 0)
  always_comb begin
    d_s = p_r[LEVELS] ^ {g_r[LEVELS][WIDTH-2:0], cin_r[LEVELS]};
  end

  // Main pipeline: reset clears everything, ce=0 holds everything
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k <= LEVELS; k++) begin
        g_r[k]   <= '0;
        p_r[k]   <= '0;
        cin_r[k] <= 1'b0;
        v_r[k]   <= 1'b0;
      end
      for (int k = 0; k < LEVELS; k++) begin
        gp_r[k] <= '0;
      end
      d_r    <= '0;
      bout_r <= 1'b0;
      vout_r <= 1'b0;
    end else if (ce) begin
      g_r[0]   <= g_in_s;
      gp_r[0]  <= p_in_s;
      p_r[0]   <= p_in_s;
      cin_r[0] <= cin_s;
      v_r[0]   <= bus.vin;
      for (int k = 1; k <= LEVELS; k++) begin
        g_r[k]   <= g_nx_s[k];
        p_r[k]   <= p_r[k-1];
        cin_r[k] <= cin_r[k-1];
        v_r[k]   <= v_r[k-1];
      end
      for (int k = 1; k < LEVELS; k++) begin
        gp_r[k] <= gp_nx_s[k];
      end
      d_r    <= d_s;
      bout_r <= ~g_r[LEVELS][WIDTH-1];
      vout_r <= v_r[LEVELS];
    end
  end

  assign bus.d    = d_r;
  assign bus.bout = bout_r;
  assign bus.vout = vout_r;

`ifdef PIPE_SUB_OVF_EN
  logic xm_r [0:LEVELS];
  logic ym_r [0:LEVELS];
  logic ovf_r;

  // Operand MSBs travel with their data so overflow lines up with d
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k <= LEVELS; k++) begin
        xm_r[k] <= 1'b0;
        ym_r[k] <= 1'b0;
      end
      ovf_r <= 1'b0;
    end else if (ce) begin
      xm_r[0] <= bus.x[WIDTH-1];
      ym_r[0] <= bus.y[WIDTH-1];
      for (int k = 1; k <= LEVELS; k++) begin
        xm_r[k] <= xm_r[k-1];
        ym_r[k] <= ym_r[k-1];
      end
      ovf_r <= (xm_r[LEVELS] ^ ym_r[LEVELS]) & (xm_r[LEVELS] ^ d_s[WIDTH-1]);
    end
  end

  assign bus.ovf = ovf_r;
`endif

endmodule

// File: tb/tb_pipe_prefix_sub.sv
// Directed bench for pipe_prefix_sub (32-bit). Build with PIPE_SUB_OVF_EN to
// also exercise the overflow output.
module tb_pipe_prefix_sub;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  logic ce;
  int   vectors = 0;
  int   miscompares = 0;

  pipe_prefix_sub_if #(.WIDTH(W)) bus ();

  pipe_prefix_sub #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .ce  (ce),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_ovf(input string tag, input logic exp);
`ifdef PIPE_SUB_OVF_EN
    chk(tag, {31'd0, bus.ovf}, {31'd0, exp});
`else
    if (exp) begin
      $display("note: %s expects ovf=1 but overflow is not built", tag);
    end else begin
      $display("note: %s ovf not built", tag);
    end
`endif
  endtask

  // One operand pair, then watch the 7-edge latency and the single-cycle vout pulse
  task automatic run_one(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic bin, input logic [W-1:0] exp_d, input logic exp_b,
                         input logic exp_o);
    bus.vin = 1'b1; bus.x = x; bus.y = y; bus.bin = bin;
    tick();
    bus.vin = 1'b0; bus.x = 32'h0; bus.y = 32'h0; bus.bin = 1'b0;
    repeat (5) tick();
    chk({tag, "_vout_edge6"}, {31'd0, bus.vout}, 32'd0);
    tick();
    chk({tag, "_vout_edge7"}, {31'd0, bus.vout}, 32'd1);
    chk({tag, "_d"}, bus.d, exp_d);
    chk({tag, "_bout"}, {31'd0, bus.bout}, {31'd0, exp_b});
    chk_ovf({tag, "_ovf"}, exp_o);
    tick();
    chk({tag, "_vout_after"}, {31'd0, bus.vout}, 32'd0);
  endtask

  initial begin
    int j;
    int en;
    int o;
    logic           ev;
    logic [W-1:0]   ed;

    bus.vin = 1'b0; bus.x = 32'h0; bus.y = 32'h0; bus.bin = 1'b0;

    // Reset with ce=0: reset must still win
    rst = 1'b1; ce = 1'b0;
    tick();
    tick();
    chk("rst_vout", {31'd0, bus.vout}, 32'd0);
    chk("rst_d", bus.d, 32'd0);
    chk("rst_bout", {31'd0, bus.bout}, 32'd0);
    chk_ovf("rst_ovf", 1'b0);
    rst = 1'b0; ce = 1'b1;

    // Single transactions and boundaries
    run_one("t1_50m15", 32'd50, 32'd15, 1'b0, 32'd35, 1'b0, 1'b0);
    run_one("t2_15m35b", 32'd15, 32'd35, 1'b1, 32'hFFFF_FFEB, 1'b1, 1'b0);
    run_one("t2_0m0b", 32'd0, 32'd0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
    run_one("bnd_eq", 32'h1234_5678, 32'h1234_5678, 1'b0, 32'd0, 1'b0, 1'b0);
    run_one("bnd_ones", 32'hFFFF_FFFF, 32'd0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);

    // Back-to-back stream of 10: x=7k, y=3k, bin=k[0] -> d=4k-bin
    for (int c = 0; c < 21; c++) begin
      if (c < 10) begin
        bus.vin = 1'b1; bus.x = 32'(7 * c); bus.y = 32'(3 * c); bus.bin = (c % 2 == 1);
      end else begin
        bus.vin = 1'b0;
      end
      tick();
      o  = c - 6;
      ev = (o >= 0) && (o < 10);
      chk("t3_vout", {31'd0, bus.vout}, {31'd0, ev});
      if (ev) begin
        chk("t3_d", bus.d, 32'(4 * o - (o % 2)));
        chk("t3_bout", {31'd0, bus.bout}, 32'd0);
      end
    end

    // Stream of 8 with a 3-cycle ce stall while results are emerging
    j = 0; en = 0; ev = 1'b0; ed = 32'd0;
    for (int c = 0; c < 22; c++) begin
      ce = !(c >= 9 && c <= 11);
      if (!ce) begin
        bus.vin = 1'b1; bus.x = 32'hDEAD_BEEF; bus.y = 32'd1; bus.bin = 1'b1;
      end else if (j < 8) begin
        bus.vin = 1'b1; bus.x = 32'(100 + 11 * j); bus.y = 32'(5 * j); bus.bin = (j % 2 == 1);
      end else begin
        bus.vin = 1'b0;
      end
      tick();
      if (ce) begin
        o  = en - 6;
        ev = (o >= 0) && (o < 8);
        if (ev) ed = 32'(100 + 6 * o - (o % 2));
        en++;
        if (j < 8) j++;
      end
      chk("t4_vout", {31'd0, bus.vout}, {31'd0, ev});
      if (ev) begin
        chk("t4_d", bus.d, ed);
        chk("t4_bout", {31'd0, bus.bout}, 32'd0);
      end
    end
    ce = 1'b1;

    // Reset mid-flight: 4 valids in, reset once the 2nd is in stage 4
    for (int c = 0; c < 5; c++) begin
      bus.vin = (c < 4); bus.x = 32'(1000 + c); bus.y = 32'(c); bus.bin = 1'b0;
      tick();
      chk("t5_pre_vout", {31'd0, bus.vout}, 32'd0);
    end
    bus.vin = 1'b0;
    rst = 1'b1;
    tick();
    chk("t5_rst_vout", {31'd0, bus.vout}, 32'd0);
    chk("t5_rst_d", bus.d, 32'd0);
    chk("t5_rst_bout", {31'd0, bus.bout}, 32'd0);
    chk_ovf("t5_rst_ovf", 1'b0);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("t5_post_vout", {31'd0, bus.vout}, 32'd0);
    end

    // Operand presented on the very edge that first samples rst=0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    run_one("rst_rel", 32'd5, 32'd3, 1'b0, 32'd2, 1'b0, 1'b0);

`ifdef PIPE_SUB_OVF_EN
    run_one("t6_ovf1", 32'h8000_0000, 32'd1, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1);
    run_one("t6_ovf0", 32'd5, 32'd3, 1'b0, 32'd2, 1'b0, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
